// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and constants for the TFF counter controller.
package tff_count_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Control/status bundle between the lab inputs and the TFF counter controller.
interface tff_count_ctrl_if #(parameter int WIDTH = 4);

    logic             start;
    logic             halt;
    logic             hold;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (output start, halt, hold, dir, limit,
                    input  count, busy, done, state);
    modport slave  (input  start, halt, hold, dir, limit,
                    output count, busy, done, state);

endinterface

// File: rtl/tff_count_ctrl_tff_bit.sv
// Single toggle flip-flop; the only storage element of the counter chain.
module tff_bit (
    input  logic clk,
    input  logic reset,
    input  logic T,
    output logic Q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  Q <= 1'b0;
        else if (T)  Q <= ~Q;
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencing controller: FSM plus capture registers driving the T inputs of a
// WIDTH-bit toggle flip-flop counter.
module tff_count_ctrl
    import tff_count_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    tff_count_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] t_bits;
    logic [WIDTH-1:0] t_up, t_dn;
    logic [WIDTH-1:0] term;

    // Ripple toggle masks: a bit flips when every lower bit is 1 (up) or 0 (down).
    assign t_up[0] = 1'b1;
    assign t_dn[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tmask
        assign t_up[i] = &count_q[i-1:0];
        assign t_dn[i] = &(~count_q[i-1:0]);
    end

    assign term = (dir_q == DIR_DOWN) ? '0 : lim_q;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        lim_d   = lim_q;
        done_d  = 1'b0;
        nxt_d   = count_q;

        case (state_q)
            RUN: begin
                if (!bus.hold) begin
                    if (count_q == term) begin
                        done_d = 1'b1;
                        if (AUTO_RELOAD) nxt_d = (dir_q == DIR_DOWN) ? lim_q : '0;
                        else             state_d = DONE;
                    end else begin
                        nxt_d = count_q ^ ((dir_q == DIR_DOWN) ? t_dn : t_up);
                    end
                end
            end
            IDLE, DONE: ;
            default: begin
                state_d = IDLE;
                nxt_d   = '0;
            end
        endcase

        if (bus.halt) begin
            state_d = IDLE;
            nxt_d   = '0;
            done_d  = 1'b0;
        end else if (bus.start) begin
            state_d = RUN;
            dir_d   = bus.dir;
            lim_d   = bus.limit;
            nxt_d   = (bus.dir == DIR_DOWN) ? bus.limit : '0;
            done_d  = 1'b0;
        end
    end

    // Every load, clear or step reaches the counter only as a set of toggles.
    assign t_bits = count_q ^ nxt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        tff_bit u_tff (
            .clk   (clk),
            .reset (reset),
            .T     (t_bits[i]),
            .Q     (count_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            lim_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            lim_q   <= lim_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for the team's T-flip-flop counter datapath. Owns a WIDTH-bit counter built only from toggle flip-flops and drives each bit's T input so the counter can be started, held, halted, reloaded and stopped at a programmable terminal count in either direction. Sits between the lab's control inputs (buttons/switches) and the TFF chain; downstream logic consumes `count`, `busy` and the one-cycle `done` pulse.

## Interface
- WIDTH, 4: counter width in bits (2..16).
- AUTO_RELOAD, 0: 1 = reload and keep running after terminal count; 0 = stop in DONE.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- start  in  1  sampled each edge; begins or restarts a run.
- halt  in  1  sampled each edge; aborts to IDLE and clears count.
- hold  in  1  freezes count while in RUN.
- dir  in  1  0 = count up, 1 = count down; captured at start.
- limit  in  WIDTH  terminal (up) or start value (down); captured at start.
- count  out  WIDTH  current counter value (TFF outputs).
- busy  out  1  high in RUN.
- done  out  1  registered one-cycle pulse at terminal count.
- state  out  2  current FSM state.

## Operation
- States: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 illegal, recovers to IDLE next edge with count cleared.
- Reset (reset=0): count=0, state=IDLE, busy=0, done=0, captured dir/limit=0, immediately and asynchronously.
- Input priority every edge: halt > start > hold.
- halt (any state): state→IDLE, count→0, done=0.
- start (any state, halt=0): capture dir_q=dir, lim_q=limit; load count with start value (up: 0, down: lim_q); state→RUN; done=0. start in RUN is a restart.
- RUN, hold=1: count and state unchanged, done=0.
- RUN, hold=0: if count==term (up: lim_q, down: 0) then done=1 for one cycle and either reload start value and stay RUN (AUTO_RELOAD=1) or go DONE with count held at term (AUTO_RELOAD=0); else count steps ±1 modulo 2^WIDTH, done=0.
- IDLE/DONE: count holds; hold and dir ignored; only start/halt act.
- Datapath rule: controller computes next value nxt and drives T = count ^ nxt; no bit is ever loaded other than by toggling. Step up: T[i] = &count[i-1:0]; step down: T[i] = &~count[i-1:0]; T[0]=1.
- limit/dir changes after start have no effect until next start.
- Up with lim_q=0 and down with lim_q=0: terminal on first RUN cycle; done after one edge.

## Timing
- start at edge E: count = start value after E; busy=1 after E.
- Up, limit L, hold=0: count reaches L after edge E+L; done=1 after edge E+L+1 for exactly one cycle; busy=0 after that edge (AUTO_RELOAD=0).
- Down, limit L: count reaches 0 after E+L, done after E+L+1.
- AUTO_RELOAD=1: done every L+1 cycles; count after the done edge = start value.
- Each hold cycle in RUN delays done by one cycle.
- done and busy are registered; no combinational path from inputs to outputs.
- Reset asserted mid-run: outputs cleared without waiting for clk; first edge after release behaves as IDLE.

## Structure
- Package tff_count_pkg: state typedef/localparams (IDLE, RUN, DONE), DIR_UP/DIR_DOWN constants.
- Sub-module tff_bit: one toggle flip-flop, ports clk, reset (async active-low), T, Q; instantiated WIDTH times via generate.
- Controller top: FSM, capture registers, nxt/T computation, done register.

## Test plan
- Reset low mid-count (count=5): count=0, state=IDLE, done=0 before next clk edge.
- WIDTH=4, dir=0, limit=5, start pulse: count 0,1,2,3,4,5; done single pulse on next edge; state=DONE, count stays 5, busy=0.
- dir=1, limit=3, hold high for 2 cycles at count=2: sequence 3,2,2,2,1,0; done one cycle later; total 6 RUN cycles.
- AUTO_RELOAD=1, limit=2: count 0,1,2,0,1,2…; done pulses every 3 cycles; busy stays 1.
- start and halt same edge while RUN at count=7: state=IDLE, count=0; start with hold=1 same edge: count loaded, no step.
- limit=15 up, limit changed to 3 during run: counts to 15, done once; limit=0 start: done after one edge.
